// File: rtl/reg_file_mp.sv
// Purpose: 2-read/2-write register file with optional zero register, write-to-read forwarding and a bulk-clear sweep engine.
// Latency: reads are combinational (0 cycles); writes commit on the rising clk edge; a clear takes NREG cycles.
// Backpressure: none; while clr_busy is high, port writes are dropped and clr_req is ignored.
// Ports: clk/rst_n      - clock, async active-low reset
//        rd_addr/rd_data - two read ports, port p at [p*AW +: AW] / [p*XLEN +: XLEN]
//        wr_en/wr_addr/wr_data - two write ports, port 1 wins on an address collision
//        clr_req/clr_busy/clr_done - bulk clear start pulse, sweep-active flag, completion pulse
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2*AW-1:0]   rd_addr,
  output logic [2*XLEN-1:0] rd_data,
  input  logic [1:0]        wr_en,
  input  logic [2*AW-1:0]   wr_addr,
  input  logic [2*XLEN-1:0] wr_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  // Sweep index must be able to hold NREG-1; RW is the width needed to select a register.
  localparam int IW = $clog2(NREG + 1);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clrState_t;

  clrState_t         state, stateNext;
  logic [IW-1:0]     clrIdx, clrIdxNext;
  logic              clrDoneNext;

  logic [XLEN-1:0]   regs [NREG];
  logic [AW-1:0]     rdA  [2];
  logic [AW-1:0]     wrA  [2];
  logic [XLEN-1:0]   wrD  [2];
  logic [1:0]        wrCommit;

  // An address is live when it exists and is not the hardwired zero register.
  function automatic logic addrLive(input logic [AW-1:0] a);
    return (32'(a) < NREG) && !(ZERO_REG && (a == '0));
  endfunction

  assign clr_busy = (state == CLEAR);

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdA[p] = rd_addr[p*AW +: AW];
      wrA[p] = wr_addr[p*AW +: AW];
      wrD[p] = wr_data[p*XLEN +: XLEN];
    end
  end

  // The sweep owns the array while running, so port writes are dropped.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wrCommit[p] = wr_en[p] && !clr_busy && addrLive(wrA[p]);
    end
  end

  // Read path: stored value, optionally overridden by same-cycle writes.
  // Port 1 is visited last so it wins, matching the storage priority.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < 2; p++) begin
      if (addrLive(rdA[p])) begin
        rd_data[p*XLEN +: XLEN] = regs[rdA[p][RW-1:0]];
        if (BYPASS) begin
          for (int q = 0; q < 2; q++) begin
            if (wrCommit[q] && (wrA[q] == rdA[p])) begin
              rd_data[p*XLEN +: XLEN] = wrD[q];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (clr_busy) begin
      regs[clrIdx[RW-1:0]] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (wrCommit[p]) begin
          regs[wrA[p][RW-1:0]] <= wrD[p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clrIdx   <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= stateNext;
      clrIdx   <= clrIdxNext;
      clr_done <= clrDoneNext;
    end
  end

  // clr_done is registered, so it lands in the first IDLE cycle after the sweep,
  // where a fresh clr_req is already accepted.
  always_comb begin
    stateNext   = state;
    clrIdxNext  = clrIdx;
    clrDoneNext = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          stateNext  = CLEAR;
          clrIdxNext = '0;
        end
      end
      CLEAR: begin
        if (clrIdx == IW'(NREG - 1)) begin
          stateNext   = IDLE;
          clrIdxNext  = '0;
          clrDoneNext = 1'b1;
        end else begin
          clrIdxNext = clrIdx + IW'(1);
        end
      end
      default: begin
        stateNext  = IDLE;
        clrIdxNext = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_file_mp.sv
`timescale 1ns/1ps
module tb_reg_file_mp;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int NREGB = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [2*AW-1:0]   rdAddr, wrAddr, rdAddrB, wrAddrB;
  logic [2*XLEN-1:0] rdData, wrData, rdDataB, wrDataB;
  logic [1:0]        wrEn, wrEnB;
  logic              clrReq, clrBusy, clrDone;
  logic              clrReqB, clrBusyB, clrDoneB;

  int checks = 0;
  int errors = 0;

  // Reference contents of the default-parameter instance.
  logic [XLEN-1:0] model [NREG];
  bit              modelBusy = 1'b0;

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rdAddr), .rd_data(rdData),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .clr_req(clrReq), .clr_busy(clrBusy), .clr_done(clrDone)
  );

  reg_file_mp #(.XLEN(XLEN), .NREG(NREGB), .AW(AW)) dutB (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rdAddrB), .rd_data(rdDataB),
    .wr_en(wrEnB), .wr_addr(wrAddrB), .wr_data(wrDataB),
    .clr_req(clrReqB), .clr_busy(clrBusyB), .clr_done(clrDoneB)
  );

  task automatic setRd(input int a0, input int a1);
    rdAddr = {AW'(a1), AW'(a0)};
  endtask

  task automatic setWr(input logic [1:0] en, input int a0, input logic [XLEN-1:0] d0,
                       input int a1, input logic [XLEN-1:0] d1);
    wrEn   = en;
    wrAddr = {AW'(a1), AW'(a0)};
    wrData = {d1, d0};
  endtask

  function automatic logic [XLEN-1:0] rdPort(input int p);
    return rdData[p*XLEN +: XLEN];
  endfunction

  // What a read of address a must return right now, from the architectural rules.
  function automatic logic [XLEN-1:0] expRead(input int a);
    logic [XLEN-1:0] r;
    int wa;
    if (a == 0 || a >= NREG) return '0;
    r = model[a];
    if (!modelBusy) begin
      for (int p = 0; p < 2; p++) begin
        wa = int'(wrAddr[p*AW +: AW]);
        if (wrEn[p] && wa == a) r = wrData[p*XLEN +: XLEN];
      end
    end
    return r;
  endfunction

  // Apply this cycle's writes to the model, then step past the clock edge.
  task automatic advance();
    int wa;
    if (!modelBusy) begin
      for (int p = 0; p < 2; p++) begin
        wa = int'(wrAddr[p*AW +: AW]);
        if (wrEn[p] && wa != 0 && wa < NREG) model[wa] = wrData[p*XLEN +: XLEN];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fillAll();
    for (int i = 0; i < NREG; i += 2) begin
      setWr(2'b11, i, $urandom | 32'h1, i + 1, $urandom | 32'h1);
      advance();
    end
    setWr(2'b00, 0, '0, 0, '0);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (clrBusy !== 1'b0 || clrDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_status busy=%b done=%b required 0/0", clrBusy, clrDone);
    end
    for (int i = 0; i < NREG; i += 2) begin
      setRd(i, i + 1);
      #1;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (rdPort(p) !== '0) begin
          errors++;
          $display("FAIL reset_read reg=%0d got=%h required=0", i + p, rdPort(p));
        end
      end
    end
    for (int i = 0; i < NREG; i++) model[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    // Write must land on the very first edge after deassertion.
    setWr(2'b01, 9, 32'hA5A5_0009, 0, '0);
    setRd(9, 9);
    advance();
    setWr(2'b00, 0, '0, 0, '0);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (rdPort(p) !== 32'hA5A5_0009) begin
        errors++;
        $display("FAIL first_write port=%0d got=%h required=a5a50009", p, rdPort(p));
      end
    end
    advance();
  endtask

  task automatic test_basic();
    setWr(2'b01, 5, 32'hDEAD_BEEF, 0, '0);
    setRd(1, 2);
    advance();
    setWr(2'b00, 0, '0, 0, '0);
    setRd(5, 5);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (rdPort(p) !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL basic_write port=%0d got=%h required=deadbeef", p, rdPort(p));
      end
    end
    advance();
  endtask

  task automatic test_zero_reg();
    setWr(2'b11, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF);
    setRd(0, 0);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (rdPort(p) !== '0) begin
        errors++;
        $display("FAIL zero_bypass port=%0d got=%h required=0", p, rdPort(p));
      end
    end
    advance();
    setWr(2'b00, 0, '0, 0, '0);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (rdPort(p) !== '0) begin
        errors++;
        $display("FAIL zero_stored port=%0d got=%h required=0", p, rdPort(p));
      end
    end
    advance();
  endtask

  task automatic test_same_addr();
    setWr(2'b11, 7, 32'h11, 7, 32'h22);
    setRd(7, 7);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (rdPort(p) !== 32'h22) begin
        errors++;
        $display("FAIL collide_bypass port=%0d got=%h required=22", p, rdPort(p));
      end
    end
    advance();
    setWr(2'b00, 0, '0, 0, '0);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (rdPort(p) !== 32'h22) begin
        errors++;
        $display("FAIL collide_stored port=%0d got=%h required=22", p, rdPort(p));
      end
    end
    advance();
  endtask

  task automatic test_random();
    int a0, a1, w0, w1;
    for (int n = 0; n < 300; n++) begin
      w0 = $urandom_range(0, NREG - 1);
      w1 = ($urandom_range(0, 3) == 0) ? w0 : $urandom_range(0, NREG - 1);
      setWr(2'($urandom_range(0, 3)), w0, $urandom, w1, $urandom);
      a0 = $urandom_range(0, 1) ? w0 : $urandom_range(0, NREG - 1);
      a1 = $urandom_range(0, 1) ? w1 : $urandom_range(0, NREG - 1);
      setRd(a0, a1);
      @(negedge clk);
      checks++;
      if (rdPort(0) !== expRead(a0)) begin
        errors++;
        $display("FAIL random_rd0 addr=%0d got=%h required=%h", a0, rdPort(0), expRead(a0));
      end
      checks++;
      if (rdPort(1) !== expRead(a1)) begin
        errors++;
        $display("FAIL random_rd1 addr=%0d got=%h required=%h", a1, rdPort(1), expRead(a1));
      end
      advance();
    end
    setWr(2'b00, 0, '0, 0, '0);
  endtask

  task automatic test_clear();
    int a0;
    bit expBusy, expDone;
    fillAll();
    clrReq = 1'b1;
    for (int k = 0; k <= 34; k++) begin
      a0 = 0;
      if (k >= 1) clrReq = (k == 10);
      if (k >= 1 && k <= 32) begin
        setWr(2'($urandom_range(1, 3)), 3, $urandom, $urandom_range(0, NREG - 1), $urandom);
        a0 = $urandom_range(0, NREG - 1);
        setRd(a0, 3);
      end else begin
        setWr(2'b00, 0, '0, 0, '0);
        setRd(0, 0);
      end
      modelBusy = (k >= 1 && k <= 32);
      expBusy   = (k >= 1 && k <= 32);
      expDone   = (k == 33);
      @(negedge clk);
      checks++;
      if (clrBusy !== expBusy || clrDone !== expDone) begin
        errors++;
        $display("FAIL clear_timing cycle=%0d busy=%b done=%b required %b/%b",
                 k, clrBusy, clrDone, expBusy, expDone);
      end
      if (modelBusy) begin
        checks++;
        if (rdPort(0) !== expRead(a0) || rdPort(1) !== expRead(3)) begin
          errors++;
          $display("FAIL clear_read cycle=%0d addr=%0d got=%h/%h required=%h/%h",
                   k, a0, rdPort(0), rdPort(1), expRead(a0), expRead(3));
        end
      end
      advance();
      // One register is zeroed per busy cycle, in ascending order.
      if (k >= 1 && k <= 32) model[k-1] = '0;
    end
    modelBusy = 1'b0;
    clrReq = 1'b0;
    for (int i = 0; i < NREG; i += 2) begin
      setRd(i, i + 1);
      @(negedge clk);
      checks++;
      if (rdPort(0) !== '0 || rdPort(1) !== '0) begin
        errors++;
        $display("FAIL clear_result regs=%0d/%0d got=%h/%h required=0", i, i + 1, rdPort(0), rdPort(1));
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    bit expBusy, expDone;
    setWr(2'b00, 0, '0, 0, '0);
    for (int k = 0; k <= 67; k++) begin
      clrReq  = (k == 0 || k == 33);
      expBusy = (k >= 1 && k <= 32) || (k >= 34 && k <= 65);
      expDone = (k == 33 || k == 66);
      @(negedge clk);
      checks++;
      if (clrBusy !== expBusy || clrDone !== expDone) begin
        errors++;
        $display("FAIL b2b_timing cycle=%0d busy=%b done=%b required %b/%b",
                 k, clrBusy, clrDone, expBusy, expDone);
      end
      advance();
    end
    clrReq = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    bit sawBusy, sawDone;
    fillAll();
    clrReq = 1'b1;
    advance();
    clrReq = 1'b0;
    for (int k = 1; k < 10; k++) advance();
    checks++;
    if (clrBusy !== 1'b1) begin
      errors++;
      $display("FAIL midclr_running busy=%b required=1", clrBusy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (clrBusy !== 1'b0 || clrDone !== 1'b0) begin
      errors++;
      $display("FAIL midclr_abort busy=%b done=%b required 0/0", clrBusy, clrDone);
    end
    for (int i = 0; i < NREG; i += 2) begin
      setRd(i, i + 1);
      #0.5;
      checks++;
      if (rdPort(0) !== '0 || rdPort(1) !== '0) begin
        errors++;
        $display("FAIL midclr_regs regs=%0d/%0d got=%h/%h required=0", i, i + 1, rdPort(0), rdPort(1));
      end
    end
    for (int i = 0; i < NREG; i++) model[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    sawBusy = 1'b0;
    sawDone = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (clrBusy) sawBusy = 1'b1;
      if (clrDone) sawDone = 1'b1;
      advance();
    end
    checks++;
    if (sawBusy || sawDone) begin
      errors++;
      $display("FAIL midclr_no_done sawBusy=%b sawDone=%b required 0/0", sawBusy, sawDone);
    end
  endtask

  task automatic test_nreg24();
    int busyCount, doneAt;
    wrEnB   = 2'b01;
    wrAddrB = {AW'(0), AW'(30)};
    wrDataB = {32'h0, 32'hCAFE_0030};
    rdAddrB = {AW'(23), AW'(30)};
    @(negedge clk);
    checks++;
    if (rdDataB[XLEN-1:0] !== '0) begin
      errors++;
      $display("FAIL n24_oor_bypass got=%h required=0", rdDataB[XLEN-1:0]);
    end
    @(posedge clk); #1;
    wrEnB   = 2'b10;
    wrAddrB = {AW'(23), AW'(0)};
    wrDataB = {32'hBEEF_0023, 32'h0};
    @(negedge clk);
    checks++;
    if (rdDataB[XLEN-1:0] !== '0 || rdDataB[2*XLEN-1:XLEN] !== 32'hBEEF_0023) begin
      errors++;
      $display("FAIL n24_oor_read got=%h/%h required=0/beef0023", rdDataB[XLEN-1:0], rdDataB[2*XLEN-1:XLEN]);
    end
    @(posedge clk); #1;
    wrEnB = 2'b00;
    @(negedge clk);
    checks++;
    if (rdDataB[2*XLEN-1:XLEN] !== 32'hBEEF_0023) begin
      errors++;
      $display("FAIL n24_top_reg got=%h required=beef0023", rdDataB[2*XLEN-1:XLEN]);
    end
    @(posedge clk); #1;
    clrReqB = 1'b1;
    @(posedge clk); #1;
    clrReqB   = 1'b0;
    busyCount = 0;
    doneAt    = -1;
    for (int k = 0; k < 40 && doneAt < 0; k++) begin
      @(negedge clk);
      if (clrBusyB) busyCount++;
      if (clrDoneB) doneAt = k + 1;
      @(posedge clk); #1;
    end
    checks++;
    if (busyCount != NREGB || doneAt != NREGB + 1) begin
      errors++;
      $display("FAIL n24_sweep busyCycles=%0d doneCycle=%0d required %0d/%0d",
               busyCount, doneAt, NREGB, NREGB + 1);
    end
    @(negedge clk);
    checks++;
    if (rdDataB[2*XLEN-1:XLEN] !== '0) begin
      errors++;
      $display("FAIL n24_cleared got=%h required=0", rdDataB[2*XLEN-1:XLEN]);
    end
  endtask

  initial begin
    setWr(2'b00, 0, '0, 0, '0);
    setRd(0, 0);
    clrReq  = 1'b0;
    wrEnB   = 2'b00;
    wrAddrB = '0;
    wrDataB = '0;
    rdAddrB = '0;
    clrReqB = 1'b0;
    test_reset();
    test_basic();
    test_zero_reg();
    test_same_addr();
    test_random();
    test_clear();
    test_back_to_back();
    test_reset_mid_clear();
    test_nreg24();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
